// File: rtl/ram_burst_reader_pkg.sv
// Shared defaults, FSM state encoding and skid-buffer sizing for the RAM burst reader.
package ram_burst_reader_pkg;

    localparam int ADDR_W_DEF  = 3;
    localparam int DATA_W_DEF  = 16;
    localparam int BUF_DEPTH   = 2;
    localparam int BUF_PTR_W   = $clog2(BUF_DEPTH);
    localparam int BUF_CNT_W   = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/ram_burst_reader_skid_fifo.sv
// Two-entry FIFO skid buffer that absorbs RAM read data while the stream consumer stalls.
module burst_skid_fifo
    import ram_burst_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0]    mem [BUF_DEPTH];
    logic [BUF_PTR_W-1:0] wr_ptr;
    logic [BUF_PTR_W-1:0] rd_ptr;
    logic [BUF_CNT_W-1:0] count;

    // Storage is cleared on reset so the stream data output reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + BUF_CNT_W'(push) - BUF_CNT_W'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == BUF_CNT_W'(BUF_DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ram_burst_reader.sv
// Reads a burst of len words from a one-cycle-latency RAM (wrapping addresses) and
// streams them out through a valid/ready interface with a 2-entry skid buffer.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        len,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        reads_left;
    logic [3:0]        words_left;
    logic              rd_vld_p1;
    logic              done_q;
    logic              buf_full;
    logic              buf_empty;
    logic              pop;
    logic              last_pop;
    logic              accept;
    logic              zero_start;
    logic [2:0]        occ;

    assign out_valid   = !buf_empty;
    assign pop         = out_valid && out_ready;
    assign last_pop    = pop && (words_left == 4'd1);
    assign out_last    = out_valid && (words_left == 4'd1);
    assign busy        = (state != S_IDLE);
    assign done        = done_q;
    assign ram_rd_addr = addr;

    // Occupancy after this cycle's pop, plus the read whose data lands next cycle.
    assign occ = (buf_full ? 3'd2 : (buf_empty ? 3'd0 : 3'd1))
               + {2'b00, rd_vld_p1} - {2'b00, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        ram_rd_en  = 1'b0;
        accept     = 1'b0;
        zero_start = 1'b0;
        case (state)
            S_IDLE: begin
                // A start landing on the done cycle is dropped.
                if (start && !done_q) begin
                    if (len != 4'd0) begin
                        accept  = 1'b1;
                        state_n = S_READ;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (occ < 3'd2) begin
                    ram_rd_en = 1'b1;
                    if (reads_left == 4'd1) begin
                        state_n = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (last_pop) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // p0 -> p1: read strobe travels with the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr       <= '0;
            reads_left <= '0;
            words_left <= '0;
            rd_vld_p1  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_vld_p1 <= ram_rd_en;
            done_q    <= zero_start || ((state == S_DRAIN) && last_pop);
            if (accept) begin
                addr       <= base_addr;
                reads_left <= len;
                words_left <= len;
            end else begin
                if (ram_rd_en) begin
                    addr       <= addr + 1'b1;
                    reads_left <= reads_left - 4'd1;
                end
                if (pop) begin
                    words_left <= words_left - 4'd1;
                end
            end
        end
    end

    burst_skid_fifo #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (rd_vld_p1),
        .din  (ram_rd_data),
        .pop  (pop),
        .dout (out_data),
        .full (buf_full),
        .empty(buf_empty)
    );

endmodule
